// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: sequences a shared max-product BCJR engine through the two
// constituent-decoder half-iterations of a turbo decoder, counts full
// iterations, honours early-stop convergence and guards each half-iteration
// with a watchdog.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_valid/ready     frame-accept handshake (ready only in IDLE)
//   num_iter              requested iteration count, sampled on accept
//   bcjr_start            one-cycle start pulse to the BCJR engine
//   bcjr_sel              0 = decoder 1 (natural), 1 = decoder 2 (interleaved)
//   bcjr_done             engine finished the current half-iteration
//   early_stop            convergence flag, qualified by a decoder-2 done
//   out_valid/ready       result handshake
//   iter_count            completed full iterations
//   busy                  controller is not idle
//   timeout_err           sticky watchdog error for the current frame
module turbo_iter_ctrl #(
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned ITER_W   = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [ITER_W-1:0] num_iter,
  output logic              bcjr_start,
  output logic              bcjr_sel,
  input  logic              bcjr_done,
  input  logic              early_stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ITER_W-1:0] MAX_ITER_L = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_SAT   = {ITER_W{1'b1}};
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]   WD_ONE     = WD_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        state, state_d;
  logic [WD_W-1:0]   wd, wd_d;
  logic [ITER_W-1:0] eff_iter, eff_iter_d;
  logic [ITER_W-1:0] iter_d;
  logic [ITER_W-1:0] iter_inc;
  logic              sel_d;
  logic              terr_d;
  logic              start_d;

  // Ready is a pure decode of the IDLE state register.
  assign frame_ready = (state == S_IDLE);

  // Saturating increment of the completed-iteration count.
  assign iter_inc = (iter_count == ITER_SAT) ? iter_count : iter_count + ITER_ONE;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    wd_d       = wd;
    eff_iter_d = eff_iter;
    iter_d     = iter_count;
    sel_d      = bcjr_sel;
    terr_d     = timeout_err;
    start_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_valid) begin
          if (num_iter == '0)             eff_iter_d = ITER_ONE;
          else if (num_iter > MAX_ITER_L) eff_iter_d = MAX_ITER_L;
          else                            eff_iter_d = num_iter;
          iter_d  = '0;
          sel_d   = 1'b0;
          terr_d  = 1'b0;
          wd_d    = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A done arriving on the timeout cycle wins over the watchdog.
        if (bcjr_done) begin
          wd_d = '0;
          if (!bcjr_sel) begin
            sel_d   = 1'b1;
            state_d = S_START;
          end else begin
            iter_d = iter_inc;
            if ((iter_inc == eff_iter) || early_stop) begin
              state_d = S_OUT;
            end else begin
              sel_d   = 1'b0;
              state_d = S_START;
            end
          end
        end else if (wd == WD_LAST) begin
          terr_d  = 1'b1;
          wd_d    = '0;
          state_d = S_DRAIN;
        end else begin
          wd_d = wd + WD_ONE;
        end
      end

      // Give a stalled engine one more watchdog window to finish before
      // reporting, so its late done cannot leak into the next frame.
      S_DRAIN: begin
        if (bcjr_done || (wd == WD_LAST)) begin
          wd_d    = '0;
          state_d = S_OUT;
        end else begin
          wd_d = wd + WD_ONE;
        end
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd          <= '0;
      eff_iter    <= ITER_ONE;
      iter_count  <= '0;
      bcjr_sel    <= 1'b0;
      timeout_err <= 1'b0;
      bcjr_start  <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      wd          <= wd_d;
      eff_iter    <= eff_iter_d;
      iter_count  <= iter_d;
      bcjr_sel    <= sel_d;
      timeout_err <= terr_d;
      bcjr_start  <= start_d;
      out_valid   <= (state_d == S_OUT);
      busy        <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Bench for turbo_iter_ctrl: table of frame vectors on a default instance plus
// directed sequences for hold/handshake, mid-frame reset and the watchdog on a
// short-timeout instance.
module tb_turbo_iter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic       rst_n, frame_valid, frame_ready, bcjr_start, bcjr_sel;
  logic       bcjr_done, early_stop, out_valid, out_ready, busy, timeout_err;
  logic [3:0] num_iter, iter_count;

  // Instance B: TIMEOUT = 16.
  logic       b_rst_n, b_frame_valid, b_frame_ready, b_bcjr_start, b_bcjr_sel;
  logic       b_bcjr_done, b_early_stop, b_out_valid, b_out_ready, b_busy, b_timeout_err;
  logic [3:0] b_num_iter, b_iter_count;

  turbo_iter_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .num_iter(num_iter), .bcjr_start(bcjr_start), .bcjr_sel(bcjr_sel),
    .bcjr_done(bcjr_done), .early_stop(early_stop), .out_valid(out_valid),
    .out_ready(out_ready), .iter_count(iter_count), .busy(busy),
    .timeout_err(timeout_err)
  );

  turbo_iter_ctrl #(.MAX_ITER(8), .ITER_W(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .frame_valid(b_frame_valid), .frame_ready(b_frame_ready),
    .num_iter(b_num_iter), .bcjr_start(b_bcjr_start), .bcjr_sel(b_bcjr_sel),
    .bcjr_done(b_bcjr_done), .early_stop(b_early_stop), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .iter_count(b_iter_count), .busy(b_busy),
    .timeout_err(b_timeout_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] ni;
    int         delay;
    int         es_at;    // decoder-2 done number carrying early_stop (0 = never)
    bit         es_d1;    // raise early_stop on every decoder-1 done
    int         exp_starts;
    int         exp_iter;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [3:0] ni, output bit ok);
    frame_valid = 1'b1;
    num_iter    = ni;
    ok          = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    frame_valid = 1'b0;
  endtask

  // Engine model for instance A: answers each start after 'delay' cycles.
  task automatic serve(input int delay, input int es_at, input bit es_d1,
                       output int starts, output int sel_err, output bit got_out);
    int cnt;
    int d2;
    cnt = -1; d2 = 0;
    starts = 0; sel_err = 0; got_out = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bcjr_done  = 1'b0;
      early_stop = 1'b0;
      if (out_valid) begin
        got_out = 1'b1;
        break;
      end
      if (bcjr_start) begin
        if (bcjr_sel !== starts[0]) sel_err++;
        starts++;
        cnt = delay;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bcjr_done = 1'b1;
          if (bcjr_sel) begin
            d2++;
            early_stop = (d2 == es_at);
          end else begin
            early_stop = es_d1;
          end
          cnt = -1;
        end
      end
    end
    bcjr_done  = 1'b0;
    early_stop = 1'b0;
  endtask

  task automatic handshake_a();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
  endtask

  task automatic accept_b(input logic [3:0] ni, output bit ok);
    b_frame_valid = 1'b1;
    b_num_iter    = ni;
    ok            = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (b_busy) begin
        ok = 1'b1;
        break;
      end
    end
    b_frame_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    bit got;
    int starts, sel_err, n, cnt;

    vecs[0] = '{ni: 4'd3,  delay: 20, es_at: 0, es_d1: 1'b0, exp_starts: 6,  exp_iter: 3};
    vecs[1] = '{ni: 4'd8,  delay: 5,  es_at: 2, es_d1: 1'b0, exp_starts: 4,  exp_iter: 2};
    vecs[2] = '{ni: 4'd0,  delay: 1,  es_at: 0, es_d1: 1'b0, exp_starts: 2,  exp_iter: 1};
    vecs[3] = '{ni: 4'd15, delay: 2,  es_at: 0, es_d1: 1'b0, exp_starts: 16, exp_iter: 8};
    vecs[4] = '{ni: 4'd1,  delay: 3,  es_at: 1, es_d1: 1'b0, exp_starts: 2,  exp_iter: 1};
    vecs[5] = '{ni: 4'd5,  delay: 7,  es_at: 0, es_d1: 1'b0, exp_starts: 10, exp_iter: 5};
    vecs[6] = '{ni: 4'd2,  delay: 4,  es_at: 0, es_d1: 1'b1, exp_starts: 4,  exp_iter: 2};

    rst_n = 1'b0; frame_valid = 1'b0; num_iter = '0; bcjr_done = 1'b0;
    early_stop = 1'b0; out_ready = 1'b0;
    b_rst_n = 1'b0; b_frame_valid = 1'b0; b_num_iter = '0; b_bcjr_done = 1'b0;
    b_early_stop = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();

    // Reset values.
    chk("rst_frame_ready", 32'(frame_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_iter", 32'(iter_count), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_start", 32'(bcjr_start), 32'd0);
    chk("rst_sel", 32'(bcjr_sel), 32'd0);
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // Stray done in IDLE is ignored.
    bcjr_done = 1'b1;
    tick();
    bcjr_done = 1'b0;
    tick();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_ready", 32'(frame_ready), 32'd1);
    chk("idle_done_start", 32'(bcjr_start), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      accept_a(vecs[i].ni, ok);
      chk($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
      serve(vecs[i].delay, vecs[i].es_at, vecs[i].es_d1, starts, sel_err, got);
      chk($sformatf("v%0d_out", i), 32'(got), 32'd1);
      chk($sformatf("v%0d_starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      chk($sformatf("v%0d_sel_seq_errs", i), 32'(sel_err), 32'd0);
      chk($sformatf("v%0d_iter", i), 32'(iter_count), 32'(vecs[i].exp_iter));
      chk($sformatf("v%0d_terr", i), 32'(timeout_err), 32'd0);
      chk($sformatf("v%0d_ready", i), 32'(frame_ready), 32'd0);
      handshake_a();
    end

    // Output held under back-pressure; frame_valid waiting is accepted one
    // cycle after the handshake; a done in OUT is ignored.
    accept_a(4'd1, ok);
    serve(3, 0, 1'b0, starts, sel_err, got);
    chk("hold_out", 32'(got), 32'd1);
    frame_valid = 1'b1;
    num_iter    = 4'd2;
    for (int c = 0; c < 10; c++) begin
      bcjr_done = (c == 4);
      tick();
      bcjr_done = 1'b0;
      chk($sformatf("hold_c%0d", c), 32'({out_valid, iter_count, frame_ready}), 32'(6'b1_0001_0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_hs_out_valid", 32'(out_valid), 32'd0);
    chk("hold_hs_ready", 32'(frame_ready), 32'd1);
    tick();
    frame_valid = 1'b0;
    chk("hold_next_accept", 32'(busy), 32'd1);
    serve(2, 0, 1'b0, starts, sel_err, got);
    chk("hold_next_starts", 32'(starts), 32'd4);
    chk("hold_next_iter", 32'(iter_count), 32'd2);
    handshake_a();

    // Reset during WAIT of iteration 2.
    accept_a(4'd3, ok);
    starts = 0; cnt = -1;
    for (int c = 0; c < 300; c++) begin
      tick();
      bcjr_done = 1'b0;
      if (bcjr_start) begin
        starts++;
        if (starts == 3) break;
        cnt = 4;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bcjr_done = 1'b1;
          cnt = -1;
        end
      end
    end
    chk("mid_iter_before_rst", 32'(iter_count), 32'd1);
    chk("mid_start_before_rst", 32'(bcjr_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs",
        32'({frame_ready, busy, bcjr_start, bcjr_sel, out_valid, iter_count, timeout_err}),
        32'(10'b1_0_0_0_0_0000_0));
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bcjr_start) n++;
    end
    chk("post_rst_no_start", 32'(n), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Watchdog: engine never finishes.
    accept_b(4'd2, ok);
    chk("to_accept", 32'(ok), 32'd1);
    tick();
    chk("to_start", 32'({b_bcjr_start, b_bcjr_sel}), 32'(2'b10));
    n = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      n++;
      if (b_out_valid) break;
    end
    chk("to_cycles", 32'(n), 32'd32);
    chk("to_terr", 32'(b_timeout_err), 32'd1);
    chk("to_iter", 32'(b_iter_count), 32'd0);
    b_bcjr_done = 1'b1;
    tick();
    b_bcjr_done = 1'b0;
    chk("to_late_done", 32'({b_out_valid, b_iter_count, b_timeout_err}), 32'(6'b1_0000_1));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("to_hs", 32'({b_out_valid, b_frame_ready, b_timeout_err}), 32'(3'b011));

    // Watchdog then a done during DRAIN ends the frame early.
    accept_b(4'd2, ok);
    chk("drain_terr_cleared", 32'(b_timeout_err), 32'd0);
    tick();
    chk("drain_start", 32'(b_bcjr_start), 32'd1);
    for (int c = 0; c < 20; c++) tick();
    chk("drain_not_out", 32'(b_out_valid), 32'd0);
    b_bcjr_done = 1'b1;
    tick();
    b_bcjr_done = 1'b0;
    chk("drain_done_out", 32'({b_out_valid, b_iter_count, b_timeout_err}), 32'(6'b1_0000_1));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    // Done on the exact timeout cycle wins.
    accept_b(4'd1, ok);
    chk("tie_terr_cleared", 32'(b_timeout_err), 32'd0);
    tick();
    chk("tie_start", 32'(b_bcjr_start), 32'd1);
    for (int c = 0; c < 15; c++) tick();
    b_bcjr_done = 1'b1;
    tick();
    b_bcjr_done = 1'b0;
    chk("tie_no_terr", 32'(b_timeout_err), 32'd0);
    tick();
    chk("tie_second_start", 32'({b_bcjr_start, b_bcjr_sel}), 32'(2'b11));
    b_bcjr_done = 1'b1;
    tick();
    b_bcjr_done = 1'b0;
    chk("tie_out", 32'({b_out_valid, b_iter_count, b_timeout_err}), 32'(6'b1_0001_0));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("tie_hs", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
